// File: rtl/mult_block_buffer.sv
// mult_block_buffer: multiply operand pairs into an external product buffer, then drain it in order
module mult_block_buffer #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_mult,
  input  logic              acc_en,
  input  logic [IN_W-1:0]   mult_input0,
  input  logic [IN_W-1:0]   mult_input1,
  output logic              RDY_mult,
  input  logic              EN_blockRead,
  input  logic [OUT_W-1:0]  readMem_val,
  output logic              EN_readMem,
  output logic [ADDR_W-1:0] readMem_addr,
  output logic              EN_writeMem,
  output logic [ADDR_W-1:0] writeMem_addr,
  output logic [OUT_W-1:0]  writeMem_val,
  output logic              VALID_memVal,
  output logic [OUT_W-1:0]  memVal_data,
  output logic              LAST_memVal,
  output logic [ADDR_W:0]   fill_count
);
  typedef enum logic [1:0] {FILL, WAIT, DRAIN, FLUSH} state_t;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t state_q;
  logic [OUT_W-1:0] acc_q, a_x, b_x, prod, val_d, wr_val_q, data_q;
  logic [ADDR_W:0] fill_count_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic rdy_q, wr_en_q, rd_en_q, p1_q, p1_last_q, valid_q, last_q;
  logic accept, drain_req, rd_last;
  // Extending both operands to OUT_W keeps the low OUT_W product bits exact in either mode.
  always_comb begin
    a_x = {{(OUT_W-IN_W){SIGNED != 0 && mult_input0[IN_W-1]}}, mult_input0};
    b_x = {{(OUT_W-IN_W){SIGNED != 0 && mult_input1[IN_W-1]}}, mult_input1};
    prod = a_x * b_x;
    val_d = acc_en ? acc_q + prod : prod;
    accept = EN_mult && rdy_q;
    drain_req = EN_blockRead && state_q == FILL && (fill_count_q != '0 || accept);
    rd_last = rd_en_q && {1'b0, rd_addr_q} == fill_count_q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      rdy_q <= 1'b0;
      fill_count_q <= '0;
      acc_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_val_q <= '0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      p1_q <= 1'b0;
      p1_last_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      wr_en_q <= accept;
      p1_q <= rd_en_q;
      p1_last_q <= rd_last;
      valid_q <= p1_q;
      last_q <= p1_last_q;
      if (p1_q) data_q <= readMem_val;
      if (accept) begin
        wr_addr_q <= fill_count_q[ADDR_W-1:0];
        wr_val_q <= val_d;
        acc_q <= val_d;
        fill_count_q <= fill_count_q + 1'b1;
      end
      case (state_q)
        FILL: begin
          rdy_q <= !drain_req && (accept ? fill_count_q + 1'b1 : fill_count_q) != FULL;
          if (drain_req) state_q <= WAIT;
        end
        WAIT: begin
          state_q <= DRAIN;
          rd_en_q <= 1'b1;
          rd_addr_q <= '0;
        end
        DRAIN: begin
          if (rd_last) begin
            rd_en_q <= 1'b0;
            state_q <= FLUSH;
          end else rd_addr_q <= rd_addr_q + 1'b1;
        end
        FLUSH: begin
          if (valid_q && last_q) begin
            state_q <= FILL;
            rdy_q <= 1'b1;
            fill_count_q <= '0;
            acc_q <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
  assign RDY_mult = rdy_q;
  assign EN_readMem = rd_en_q;
  assign readMem_addr = rd_addr_q;
  assign EN_writeMem = wr_en_q;
  assign writeMem_addr = wr_addr_q;
  assign writeMem_val = wr_val_q;
  assign VALID_memVal = valid_q;
  assign memVal_data = data_q;
  assign LAST_memVal = last_q;
  assign fill_count = fill_count_q;
endmodule

// File: tb/tb_mult_block_buffer.sv
// tb_mult_block_buffer: directed bench for an unsigned DEPTH=64 and a signed DEPTH=8 instance sharing stimulus
module tb_mult_block_buffer;
  logic clk = 0, rst = 1, en = 0, acc = 0, br = 0;
  logic [15:0] a = 0, b = 0;
  always #5 clk = ~clk;
  logic rdy0, rre0, we0, v0, l0, rdy1, rre1, we1, v1, l1;
  logic [5:0] ra0, wa0;
  logic [2:0] ra1, wa1;
  logic [6:0] fc0;
  logic [3:0] fc1;
  logic [31:0] wv0, d0, rv0, wv1, d1, rv1;
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [8];
  mult_block_buffer #(.IN_W(16), .OUT_W(32), .DEPTH(64), .SIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .EN_mult(en), .acc_en(acc), .mult_input0(a), .mult_input1(b),
    .RDY_mult(rdy0), .EN_blockRead(br), .readMem_val(rv0), .EN_readMem(rre0), .readMem_addr(ra0),
    .EN_writeMem(we0), .writeMem_addr(wa0), .writeMem_val(wv0), .VALID_memVal(v0),
    .memVal_data(d0), .LAST_memVal(l0), .fill_count(fc0));
  mult_block_buffer #(.IN_W(16), .OUT_W(32), .DEPTH(8), .SIGNED(1)) dut1 (
    .clk(clk), .rst(rst), .EN_mult(en), .acc_en(acc), .mult_input0(a), .mult_input1(b),
    .RDY_mult(rdy1), .EN_blockRead(br), .readMem_val(rv1), .EN_readMem(rre1), .readMem_addr(ra1),
    .EN_writeMem(we1), .writeMem_addr(wa1), .writeMem_val(wv1), .VALID_memVal(v1),
    .memVal_data(d1), .LAST_memVal(l1), .fill_count(fc1));
  always @(posedge clk) begin
    if (we0) mem0[wa0] <= wv0;
    if (rre0) rv0 <= mem0[ra0];
    if (we1) mem1[wa1] <= wv1;
    if (rre1) rv1 <= mem1[ra1];
  end
  int errs = 0, checks = 0, nwe0 = 0, nre0 = 0;
  logic [31:0] q0[$], q1[$], exp0[$], exp1[$];
  logic lq0[$], lq1[$];
  always @(negedge clk) begin
    if (v0) begin q0.push_back(d0); lq0.push_back(l0); end
    if (v1) begin q1.push_back(d1); lq1.push_back(l1); end
    if (we0) nwe0 = nwe0 + 1;
    if (rre0) nre0 = nre0 + 1;
  end
  typedef struct { logic [15:0] a, b; logic ac; logic [31:0] eu, es; } vec_t;
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic push(input logic [15:0] pa, input logic [15:0] pb, input logic pac, input logic pbr);
    en = 1; a = pa; b = pb; acc = pac; br = pbr;
    step();
    en = 0; br = 0; acc = 0;
  endtask
  task automatic do_reset();
    rst = 1; en = 0; br = 0; acc = 0;
    step(2);
    chk("rst_rdy", 32'(rdy0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_last", 32'(l0), 0);
    chk("rst_we", 32'(we0), 0);
    chk("rst_re", 32'(rre0), 0);
    chk("rst_fc", 32'(fc0), 0);
    rst = 0;
    step();
    chk("post_rst_rdy0", 32'(rdy0), 1);
    chk("post_rst_rdy1", 32'(rdy1), 1);
  endtask
  // Call from cycle n+1 of a drain request; checks timing and the streamed entries of both instances.
  task automatic drain_run(input int n0, input int n1, input bit hold);
    int k, r0, r1, f0, f1, w;
    k = 1; r0 = -1; r1 = -1; f0 = -1; f1 = -1; w = 0;
    q0.delete(); lq0.delete(); q1.delete(); lq1.delete();
    nwe0 = 0;
    if (hold) begin en = 1; a = 9; b = 9; end
    while ((r0 < 0 || r1 < 0) && k < 200) begin
      if (v0 && f0 < 0) f0 = k;
      if (v1 && f1 < 0) f1 = k;
      if (rdy0 && r0 < 0) r0 = k;
      if (rdy1 && r1 < 0) r1 = k;
      if (hold && k == 3) chk("drain_fc_hold", 32'(fc0), 32'(n0));
      if (k == 4) begin w = nwe0; en = 0; end
      step();
      k++;
    end
    if (hold) chk("drain_no_write", 32'(w), 0);
    chk("first_valid0", 32'(f0), 4);
    chk("first_valid1", 32'(f1), 4);
    chk("rdy_back0", 32'(r0), 32'(n0 + 4));
    chk("rdy_back1", 32'(r1), 32'(n1 + 4));
    chk("beats0", 32'(q0.size()), 32'(n0));
    chk("beats1", 32'(q1.size()), 32'(n1));
    for (int i = 0; i < n0 && i < q0.size(); i++) begin
      chk("beat0", q0[i], exp0[i]);
      chk("last0", 32'(lq0[i]), 32'(i == n0 - 1));
    end
    for (int i = 0; i < n1 && i < q1.size(); i++) begin
      chk("beat1", q1[i], exp1[i]);
      chk("last1", 32'(lq1[i]), 32'(i == n1 - 1));
    end
    chk("fc_cleared", 32'(fc0), 0);
  endtask
  initial begin
    int k, s;
    tbl[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 32'h00000001};
    tbl[1] = '{16'h0002, 16'h0003, 1'b0, 32'd6, 32'd6};
    tbl[2] = '{16'h0004, 16'h0005, 1'b1, 32'd26, 32'd26};
    tbl[3] = '{16'h0001, 16'h0001, 1'b1, 32'd27, 32'd27};
    tbl[4] = '{16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, 32'hFFFFFFEB};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000, 32'h40000000};
    tbl[6] = '{16'h8000, 16'h8000, 1'b1, 32'h80000000, 32'h80000000};
    do_reset();
    nre0 = 0;
    br = 1;
    step();
    br = 0;
    step(3);
    chk("empty_req_reads", 32'(nre0), 0);
    chk("empty_req_rdy", 32'(rdy0), 1);
    exp0.delete(); exp1.delete();
    for (int i = 0; i < 7; i++) begin
      push(tbl[i].a, tbl[i].b, tbl[i].ac, 1'b0);
      chk("vec_we", 32'(we0), 1);
      chk("vec_addr", 32'(wa0), 32'(i));
      chk("vec_unsigned", wv0, tbl[i].eu);
      chk("vec_signed", wv1, tbl[i].es);
      chk("vec_fc", 32'(fc0), 32'(i + 1));
      exp0.push_back(tbl[i].eu);
      exp1.push_back(tbl[i].es);
    end
    br = 1;
    step();
    br = 0;
    drain_run(7, 7, 1'b1);
    push(16'd2, 16'd2, 1'b1, 1'b0);
    chk("acc_cleared0", wv0, 4);
    chk("acc_cleared1", wv1, 4);
    do_reset();
    exp0.delete(); exp1.delete();
    for (int i = 0; i < 5; i++) begin
      push(16'(i), 16'd2, 1'b0, i == 4);
      exp0.push_back(32'(2 * i));
      exp1.push_back(32'(2 * i));
    end
    drain_run(5, 5, 1'b0);
    do_reset();
    exp0.delete(); exp1.delete();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("rdy_before_full", 32'(rdy0), 1);
      push(16'(i), 16'd3, 1'b0, 1'b0);
      exp0.push_back(32'(3 * i));
      if (i < 8) exp1.push_back(32'(3 * i));
      if (i == 7) chk("rdy_full1", 32'(rdy1), 0);
    end
    chk("rdy_full0", 32'(rdy0), 0);
    chk("fc_full0", 32'(fc0), 64);
    chk("fc_full1", 32'(fc1), 8);
    br = 1;
    step();
    br = 0;
    drain_run(64, 8, 1'b0);
    do_reset();
    for (int i = 0; i < 12; i++) push(16'(i), 16'd1, 1'b0, 1'b0);
    q0.delete(); lq0.delete();
    br = 1;
    step();
    br = 0;
    k = 0;
    while (q0.size() < 10 && k < 100) begin step(); k++; end
    chk("rst_drain_reached", 32'(q0.size() >= 10), 1);
    rst = 1;
    step();
    chk("rst_drain_valid", 32'(v0), 0);
    chk("rst_drain_rdy", 32'(rdy0), 0);
    rst = 0;
    step();
    chk("rst_drain_rdy_back", 32'(rdy0), 1);
    chk("rst_drain_fc", 32'(fc0), 0);
    s = q0.size();
    step(5);
    chk("rst_drain_no_beats", 32'(q0.size()), 32'(s));
    push(16'd1, 16'd1, 1'b1, 1'b0);
    chk("rst_acc_cleared0", wv0, 1);
    chk("rst_acc_cleared1", wv1, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
